// File: rtl/serial_adder_sequencer_pkg.sv
// Shared definitions for the bit-serial adder sequencer.
// Holds the FSM state encodings used by the sequencer top.
package serial_adder_sequencer_pkg;

   typedef logic [1:0] state_t;

   localparam state_t STATE_IDLE = 2'd0;
   localparam state_t STATE_RUN  = 2'd1;
   localparam state_t STATE_DONE = 2'd2;

endpackage

// File: rtl/serial_adder_sequencer_fa.sv
// Single-bit full adder cell shared as the serial datapath.
// Ports: a, b, cin in; s (sum bit), cout (carry) out.
module serial_adder_sequencer_fa (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_sequencer.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, one bit per clock.
// Ports: Clock, Reset (sync, high), Start, OperandA/B, InputCarry in;
//        Busy, Done (pulse), Sum, OutputCarry (registered) out.
module serial_adder_sequencer
   import serial_adder_sequencer_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Start,
   input  logic [WIDTH-1:0] OperandA,
   input  logic [WIDTH-1:0] OperandB,
   input  logic             InputCarry,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Sum,
   output logic             OutputCarry
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] ps;
   logic [WIDTH-1:0] ps_nxt;
   logic             fa_s;
   logic             fa_co;

   serial_adder_sequencer_fa u_fa (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .cin  (carry),
      .s    (fa_s),
      .cout (fa_co)
   );

   // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at LSB.
   always_comb begin
      ps_nxt = ps >> 1;
      ps_nxt[WIDTH-1] = fa_s;
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state       <= STATE_IDLE;
         cnt         <= '0;
         carry       <= 1'b0;
         a_sr        <= '0;
         b_sr        <= '0;
         ps          <= '0;
         Sum         <= '0;
         OutputCarry <= 1'b0;
      end else begin
         case (state)
            STATE_IDLE, STATE_DONE: begin
               if (Start) begin
                  a_sr  <= OperandA;
                  b_sr  <= OperandB;
                  carry <= InputCarry;
                  cnt   <= '0;
                  ps    <= '0;
                  state <= STATE_RUN;
               end else begin
                  state <= STATE_IDLE;
               end
            end
            STATE_RUN: begin
               a_sr  <= a_sr >> 1;
               b_sr  <= b_sr >> 1;
               ps    <= ps_nxt;
               carry <= fa_co;
               cnt   <= cnt + CW'(1);
               if (cnt == LAST) begin
                  state       <= STATE_DONE;
                  Sum         <= ps_nxt;
                  OutputCarry <= fa_co;
               end
            end
            default: state <= STATE_IDLE;
         endcase
      end
   end

   assign Busy = (state == STATE_RUN);
   assign Done = (state == STATE_DONE);

endmodule
